// File: rtl/message_typer_pkg.sv
// Shared letter-code constants and the typer state encoding for the HUD message path.
package message_typer_pkg;

   localparam int LETTER_CODE_WIDTH = 4;
   localparam logic [LETTER_CODE_WIDTH-1:0] LETTER_BLANK = 4'd0;
   localparam int MAX_SLOTS = 15;

   typedef enum logic [1:0] {
      TYPER_IDLE,
      TYPER_TYPING,
      TYPER_BLINK,
      TYPER_SHOW
   } typer_state_t;

endpackage

// File: rtl/message_typer_frame_divider.sv
// Counts start-of-frame pulses and flags the pulse that completes each PERIOD-long interval.
module frame_divider #(
   parameter int PERIOD = 8,
   parameter int CNT_W  = 3
) (
   input  logic clk,
   input  logic resetN,
   input  logic enable,
   input  logic restart,
   input  logic frame,
   output logic tick
);

   logic [CNT_W-1:0] cnt;
   logic             at_end;

   assign at_end = (cnt == CNT_W'(PERIOD - 1));
   // Restart dominates, so a frame pulse coinciding with it never counts.
   assign tick   = enable && !restart && frame && at_end;

   always_ff @(posedge clk) begin
      if (!resetN || restart) begin
         cnt <= '0;
      end else if (enable && frame) begin
         cnt <= at_end ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/message_typer.sv
// Latches a HUD message, reveals it one slot per interval, blinks it, then holds it until cleared.
module message_typer
   import message_typer_pkg::*;
#(
   parameter int NUM_SLOTS         = 8,
   parameter int FRAMES_PER_LETTER = 8,
   parameter int BLINK_FRAMES      = 16,
   parameter int BLINK_TOGGLES     = 6
) (
   input  logic                                            clk,
   input  logic                                            resetN,
   input  logic                                            startOfFrame,
   input  logic                                            start,
   input  logic                                            clear,
   input  logic [NUM_SLOTS-1:0][LETTER_CODE_WIDTH-1:0]     message,
   input  logic [3:0]                                      msgLength,
   output logic [NUM_SLOTS-1:0][LETTER_CODE_WIDTH-1:0]     letters,
   output logic [NUM_SLOTS-1:0]                            slotVisible,
   output logic                                            busy,
   output logic                                            done
);

   localparam int MAX_PERIOD = (FRAMES_PER_LETTER > BLINK_FRAMES) ? FRAMES_PER_LETTER : BLINK_FRAMES;
   localparam int FRAME_W    = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
   localparam int TOG_W      = $clog2(BLINK_TOGGLES + 1);

   typer_state_t                                state;
   logic [3:0]                                  len;
   logic [3:0]                                  reveal_count;
   logic [TOG_W-1:0]                            toggle_cnt;
   logic [3:0]                                  start_len;
   logic [NUM_SLOTS-1:0][LETTER_CODE_WIDTH-1:0] start_letters;
   logic                                        reveal_tick;
   logic                                        blink_tick;

   function automatic logic [NUM_SLOTS-1:0] low_mask(input logic [3:0] n);
      logic [NUM_SLOTS-1:0] m;
      for (int i = 0; i < NUM_SLOTS; i++) m[i] = (4'(i) < n);
      return m;
   endfunction

   // Clamp the requested length and blank slots beyond it at latch time.
   always_comb begin
      start_len = (msgLength > 4'(NUM_SLOTS)) ? 4'(NUM_SLOTS) : msgLength;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         start_letters[i] = (4'(i) < start_len) ? message[i] : LETTER_BLANK;
      end
   end

   frame_divider #(.PERIOD(FRAMES_PER_LETTER), .CNT_W(FRAME_W)) u_reveal_div (
      .clk     (clk),
      .resetN  (resetN),
      .enable  (state == TYPER_TYPING),
      .restart ((state != TYPER_TYPING) || start || clear),
      .frame   (startOfFrame),
      .tick    (reveal_tick)
   );

   frame_divider #(.PERIOD(BLINK_FRAMES), .CNT_W(FRAME_W)) u_blink_div (
      .clk     (clk),
      .resetN  (resetN),
      .enable  (state == TYPER_BLINK),
      .restart ((state != TYPER_BLINK) || start || clear),
      .frame   (startOfFrame),
      .tick    (blink_tick)
   );

   always_ff @(posedge clk) begin
      if (!resetN || clear) begin
         state        <= TYPER_IDLE;
         letters      <= '0;
         slotVisible  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         len          <= '0;
         reveal_count <= '0;
         toggle_cnt   <= '0;
      end else if (start) begin
         letters    <= start_letters;
         len        <= start_len;
         toggle_cnt <= '0;
         if (start_len == 4'd0) begin
            state        <= TYPER_SHOW;
            slotVisible  <= '0;
            reveal_count <= '0;
            busy         <= 1'b0;
            done         <= 1'b1;
         end else begin
            state        <= TYPER_TYPING;
            slotVisible  <= NUM_SLOTS'(1);
            reveal_count <= 4'd1;
            busy         <= 1'b1;
            done         <= 1'b0;
         end
      end else begin
         case (state)
            TYPER_TYPING: begin
               if (reveal_count >= len) begin
                  state      <= TYPER_BLINK;
                  toggle_cnt <= '0;
               end else if (reveal_tick) begin
                  slotVisible  <= low_mask(reveal_count + 4'd1);
                  reveal_count <= reveal_count + 4'd1;
                  if (reveal_count + 4'd1 == len) begin
                     state      <= TYPER_BLINK;
                     toggle_cnt <= '0;
                  end
               end
            end
            // Odd toggle numbers blank the word, even ones restore it, so the last toggle lands visible.
            TYPER_BLINK: begin
               if (blink_tick) begin
                  slotVisible <= toggle_cnt[0] ? low_mask(len) : '0;
                  toggle_cnt  <= toggle_cnt + 1'b1;
                  if (toggle_cnt == TOG_W'(BLINK_TOGGLES - 1)) begin
                     state <= TYPER_SHOW;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            TYPER_SHOW: begin
               slotVisible <= low_mask(len);
            end
            default: begin
               slotVisible <= '0;
            end
         endcase
      end
   end

endmodule
